// File: rtl/ui_debounce.sv
// rtl/ui_debounce.sv - per-channel 2-flop synchroniser and stable-time debounce with edge pulses
module ui_debounce #(
    parameter int unsigned  WIDTH        = 8,
    parameter logic [23:0]  STABLE_COUNT = 24'd500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Counter only ever reaches STABLE_COUNT-1 before being cleared, so clog2 bits suffice.
    localparam int unsigned CNT_W = $clog2(STABLE_COUNT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_COUNT - 24'd1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] dout_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // Per-channel debounce decision: clear on agreement, count on disagreement, commit at terminal count.
    always_comb begin
        dout_nxt = dout;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != dout[i]) begin
                if (cnt[i] == TERM) begin
                    dout_nxt[i] = sync2[i];
                    rise_nxt[i] = sync2[i];
                    fall_nxt[i] = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // All state registered here so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            dout    <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= din;
            sync2   <= sync1;
            dout    <= dout_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            changed <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
